// File: rtl/irq_pending_reg_if.sv
// Request/mask/acknowledge bundle between the interrupt source side and irq_pending_reg.
// Latency: none, wires only.
// Backpressure: none; requests are sticky in the register and released by acknowledge.
// master: drives irq_in, mask_we/mask_wdata, ack_valid/ack_idx; observes mask, pend_vec, pend_valid, ovf.
// slave : the pending register itself (mirror of master).
interface irq_pending_reg_if #(
   parameter int N  = 8,
   parameter int IW = 3
);
   logic [N-1:0]  irq_in;
   logic          mask_we;
   logic [N-1:0]  mask_wdata;
   logic          ack_valid;
   logic [IW-1:0] ack_idx;
   logic [N-1:0]  mask;
   logic [N-1:0]  pend_vec;
   logic          pend_valid;
   logic [N-1:0]  ovf;

   modport master (
      output irq_in, mask_we, mask_wdata, ack_valid, ack_idx,
      input  mask, pend_vec, pend_valid, ovf
   );

   modport slave (
      input  irq_in, mask_we, mask_wdata, ack_valid, ack_idx,
      output mask, pend_vec, pend_valid, ovf
   );
endinterface

// File: rtl/irq_pending_reg.sv
// Synchronises N async request lines, latches sticky pending bits, masks them for the encoder.
// Latency: irq_in to pend_vec is 2 cycles (edge capture) or 3 cycles (level capture); ack/mask 1 cycle.
// Backpressure: none; a request stays pending until acknowledged, repeats are flagged in ovf.
// Ports: clk, rst_n (synchronous, active-low), bus (irq_pending_reg_if.slave).
// Build option: define IRQ_EDGE_EN for rising-edge capture; default is level capture.
module irq_pending_reg #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   irq_pending_reg_if.slave   bus
);

   logic [N-1:0] s1_q, s1_d;
   logic [N-1:0] s2_q, s2_d;
   logic [N-1:0] pend_q, pend_d;
   logic [N-1:0] ovf_q, ovf_d;
   logic [N-1:0] mask_q, mask_d;
   logic [N-1:0] evt;
   logic [N-1:0] clr;
`ifdef IRQ_EDGE_EN
   // vld_q[1] says s2 holds a real sample rather than its reset value, so a
   // line already high when reset releases is not mistaken for a fresh edge.
   logic [1:0]   vld_q, vld_d;
`endif

   always_comb begin
      s1_d = bus.irq_in;
      s2_d = s1_q;
`ifdef IRQ_EDGE_EN
      vld_d = {vld_q[0], 1'b1};
      evt   = s1_q & ~s2_q & {N{vld_q[1]}};
`else
      evt   = s2_q;
`endif
      // Indices >= N never match, so out-of-range acknowledges do nothing.
      clr = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.ack_valid && (bus.ack_idx == IW'(i))) begin
            clr[i] = 1'b1;
         end
      end
      // A new event beats a same-cycle clear so it is never lost.
      pend_d = evt | (pend_q & ~clr);
      // Overrun only counts when the event lands on a bit that is not being
      // cleared; an acknowledge therefore always wipes the flag.
      ovf_d  = ~clr & (ovf_q | (evt & pend_q));
      mask_d = bus.mask_we ? bus.mask_wdata : mask_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q   <= '0;
         s2_q   <= '0;
         pend_q <= '0;
         ovf_q  <= '0;
         mask_q <= '1;
`ifdef IRQ_EDGE_EN
         vld_q  <= '0;
`endif
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         mask_q <= mask_d;
`ifdef IRQ_EDGE_EN
         vld_q  <= vld_d;
`endif
      end
   end

   // Outputs come only from registers; unmasking exposes a held bit at once.
   assign bus.mask       = mask_q;
   assign bus.pend_vec   = pend_q & mask_q;
   assign bus.pend_valid = |(pend_q & mask_q);
   assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_irq_pending_reg.sv
// Directed bench for irq_pending_reg with a sample-history model checked every cycle.
// Latency: model updates on each rising edge, outputs compared on the falling edge.
// Backpressure: not applicable; stimulus is a fixed directed sequence.
module tb_irq_pending_reg;

   localparam int N = 8;
`ifdef IRQ_EDGE_EN
   localparam int  LAT  = 2;
   localparam bit  EDGE = 1'b1;
`else
   localparam int  LAT  = 3;
   localparam bit  EDGE = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   bit   cmp_en;
   bit   ovf_ign;

   irq_pending_reg_if #(.N(N), .IW(3)) bus ();

   irq_pending_reg #(.N(N), .IW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: remembers the raw line samples taken since reset and applies the
   // pending / overrun / mask rules per line.
   logic [N-1:0] samp[$];
   logic [N-1:0] m_pend;
   logic [N-1:0] m_ovf;
   logic [N-1:0] m_mask;

   initial begin
      m_pend = '0;
      m_ovf  = '0;
      m_mask = '1;
   end

   always @(posedge clk) begin
      logic [N-1:0] ev;
      logic [N-1:0] old_pend;
      int           hit;
      if (!rst_n) begin
         samp.delete();
         m_pend = '0;
         m_ovf  = '0;
         m_mask = '1;
      end else begin
         ev = '0;
         if (samp.size() > 1) begin
            // samp[0]: line seen one edge ago, samp[1]: two edges ago
            ev = EDGE ? (samp[0] & ~samp[1]) : samp[1];
         end
         hit = bus.ack_valid ? int'(bus.ack_idx) : -1;
         old_pend = m_pend;
         for (int i = 0; i < N; i++) begin
            if (i == hit) begin
               m_pend[i] = ev[i];
               m_ovf[i]  = 1'b0;
            end else if (ev[i]) begin
               m_pend[i] = 1'b1;
               if (old_pend[i]) m_ovf[i] = 1'b1;
            end
         end
         if (bus.mask_we) m_mask = bus.mask_wdata;
         samp.push_front(bus.irq_in);
         if (samp.size() > 2) void'(samp.pop_back());
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_pend_vec", 32'(bus.pend_vec), 32'(m_pend & m_mask));
         chk("cyc_pend_valid", 32'(bus.pend_valid), 32'(|(m_pend & m_mask)));
         chk("cyc_mask", 32'(bus.mask), 32'(m_mask));
         if (!ovf_ign) chk("cyc_ovf", 32'(bus.ovf), 32'(m_ovf));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [N-1:0] v);
      bus.irq_in = v;
      step(1);
      bus.irq_in = '0;
   endtask

   task automatic ack(input logic [2:0] idx);
      bus.ack_valid = 1'b1;
      bus.ack_idx   = idx;
      step(1);
      bus.ack_valid = 1'b0;
   endtask

   task automatic wmask(input logic [N-1:0] v);
      bus.mask_we    = 1'b1;
      bus.mask_wdata = v;
      step(1);
      bus.mask_we    = 1'b0;
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      cmp_en         = 1'b0;
      ovf_ign        = 1'b0;
      rst_n          = 1'b0;
      bus.irq_in     = '0;
      bus.mask_we    = 1'b0;
      bus.mask_wdata = '0;
      bus.ack_valid  = 1'b0;
      bus.ack_idx    = '0;

      // reset state
      step(1);
      cmp_en = 1'b1;
      step(1);
      rst_n = 1'b1;
      step(5);
      chk("rst_pend_vec", 32'(bus.pend_vec), 32'h00);
      chk("rst_pend_valid", 32'(bus.pend_valid), 32'h0);
      chk("rst_mask", 32'(bus.mask), 32'hFF);
      chk("rst_ovf", 32'(bus.ovf), 32'h00);

      // capture latency and acknowledge
      pulse(8'h24);
      chk("lat_not_early", 32'(bus.pend_vec), 32'h00);
      step(LAT - 1);
      chk("lat_capture", 32'(bus.pend_vec), 32'h24);
      step(3);
      chk("lat_held", 32'(bus.pend_vec), 32'h24);
      ack(3'd5);
      chk("ack5_pend_vec", 32'(bus.pend_vec), 32'h04);
      ack(3'd2);
      chk("ack2_pend_vec", 32'(bus.pend_vec), 32'h00);
      chk("ack2_pend_valid", 32'(bus.pend_valid), 32'h0);

      // mask hide / expose
      wmask(8'h0F);
      chk("mask_write", 32'(bus.mask), 32'h0F);
      pulse(8'h80);
      step(4);
      chk("mask_hidden", 32'(bus.pend_vec), 32'h00);
      chk("mask_hidden_valid", 32'(bus.pend_valid), 32'h0);
      wmask(8'hFF);
      chk("mask_expose", 32'(bus.pend_vec), 32'h80);
      ack(3'd7);
      step(1);

      // set wins over a same-cycle clear
      pulse(8'h08);
      step(4);
      chk("sw_first", 32'(bus.pend_vec), 32'h08);
      pulse(8'h08);
      step(LAT - 2);
      ack(3'd3);
      chk("sw_pend3", 32'(bus.pend_vec[3]), 32'h1);
      chk("sw_ovf3", 32'(bus.ovf[3]), 32'h0);
      ack(3'd3);
      chk("sw_cleanup", 32'(bus.pend_vec), 32'h00);

      // overrun
      pulse(8'h02);
      step(4);
      pulse(8'h02);
      step(4);
      chk("ovr_ovf", 32'(bus.ovf), 32'h02);
      chk("ovr_pend", 32'(bus.pend_vec), 32'h02);
      ack(3'd1);
      chk("ovr_ack_ovf", 32'(bus.ovf), 32'h00);
      chk("ovr_ack_pend1", 32'(bus.pend_vec[1]), 32'h0);

      // reset mid-operation
      pulse(8'hA5);
      step(4);
      chk("mid_pend", 32'(bus.pend_vec), 32'hA5);
      wmask(8'h0F);
      chk("mid_masked", 32'(bus.pend_vec), 32'h05);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      chk("mid_rst_pend_vec", 32'(bus.pend_vec), 32'h00);
      chk("mid_rst_valid", 32'(bus.pend_valid), 32'h0);
      chk("mid_rst_mask", 32'(bus.mask), 32'hFF);
      chk("mid_rst_ovf", 32'(bus.ovf), 32'h00);

      // line held high across reset release
      bus.irq_in = 8'h40;
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      ovf_ign = !EDGE;
      step(5);
      chk("held_after_rst", 32'(bus.pend_vec), EDGE ? 32'h00 : 32'h40);
      bus.irq_in = '0;
      step(4);
      chk("held_fall", 32'(bus.pend_vec), EDGE ? 32'h00 : 32'h40);
      pulse(8'h40);
      step(4);
      chk("held_rerise", 32'(bus.pend_vec), 32'h40);
      ack(3'd6);
      ovf_ign = 1'b0;
      chk("held_ack", 32'(bus.pend_vec), 32'h00);
      chk("held_ack_ovf", 32'(bus.ovf), 32'h00);
      step(3);

      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
